// File: rtl/texture_pkg.sv
// texture_pkg: texture geometry, palette width and ROM address layout shared by the renderers.
package texture_pkg;
    localparam int TEX_DIM      = 16;
    localparam int TEXEL_W      = $clog2(TEX_DIM);
    localparam int PAL_IDX_W    = 8;
    localparam int TEX_ID_W_DEF = 2;
    typedef struct packed {
        logic [TEX_ID_W_DEF-1:0] tex_id;
        logic [TEXEL_W-1:0]      v;
        logic [TEXEL_W-1:0]      u;
    } tex_addr_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick of the first eligible index at or after rr_ptr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  winner,
    output logic          any
);
    // Walk from lowest to highest priority so the closest index to rr_ptr overwrites the rest.
    always_comb begin
        winner = '0;
        for (int k = N - 1; k >= 0; k--)
            winner = eligible[(int'(rr_ptr) + k) % N] ? N'(1) << ((int'(rr_ptr) + k) % N) : winner;
    end
    assign any = |eligible;
endmodule

// File: rtl/texture_rom_arbiter.sv
// texture_rom_arbiter: round-robin sharing of one texture ROM read port with tagged, in-order data return.
module texture_rom_arbiter
    import texture_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int TEX_ID_W = 2,
    parameter int ROM_LAT  = 1
) (
    input  logic                            vga_clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*TEX_ID_W-1:0]     tex_id,
    input  logic [NUM_REQ*TEXEL_W-1:0]      tex_u,
    input  logic [NUM_REQ*TEXEL_W-1:0]      tex_v,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [TEX_ID_W+2*TEXEL_W-1:0]   rom_address,
    input  logic [PAL_IDX_W-1:0]            rom_q,
    output logic [NUM_REQ-1:0]              rvalid,
    output logic [PAL_IDX_W-1:0]            rdata,
    output logic                            busy
);
    localparam int PW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] eligible, winner;
    logic               any;
    logic [PW-1:0]      rr_ptr, win_idx;
    logic [ROM_LAT-1:0] tag_v;
    logic [PW-1:0]      tag_id [ROM_LAT];
    // A client granted last cycle is masked so it cannot hog the port while it updates its request.
    assign eligible = req & ~gnt;
    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .eligible(eligible),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any     (any)
    );
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            win_idx = winner[i] ? PW'(i) : win_idx;
    end
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt         <= '0;
            rom_address <= '0;
            rr_ptr      <= '0;
            tag_v       <= '0;
            for (int i = 0; i < ROM_LAT; i++) tag_id[i] <= '0;
            rvalid      <= '0;
            rdata       <= '0;
        end else begin
            gnt       <= winner;
            tag_v[0]  <= any;
            tag_id[0] <= win_idx;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            if (any) begin
                rom_address <= {tex_id[win_idx*TEX_ID_W +: TEX_ID_W],
                                tex_v[win_idx*TEXEL_W +: TEXEL_W],
                                tex_u[win_idx*TEXEL_W +: TEXEL_W]};
                rr_ptr      <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            // Untagged ROM reads still happen every cycle; only tagged ones reach a client.
            rvalid <= tag_v[ROM_LAT-1] ? NUM_REQ'(1) << tag_id[ROM_LAT-1] : '0;
            if (tag_v[ROM_LAT-1]) rdata <= rom_q;
        end
    end
    assign busy = |gnt | |tag_v | |rvalid;
endmodule

// File: tb/tb_texture_rom_arbiter.sv
// tb_texture_rom_arbiter: directed checks of grant order, addressing, data return and reset behaviour.
module tb_texture_rom_arbiter;
    localparam int N  = 4;
    localparam int TW = 2;
    localparam int LAT = 1;
    logic            vga_clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*TW-1:0] tex_id = '0;
    logic [N*4-1:0]  tex_u = '0;
    logic [N*4-1:0]  tex_v = '0;
    logic [N-1:0]    gnt, rvalid;
    logic [TW+7:0]   rom_address;
    logic [7:0]      rom_q = '0;
    logic [7:0]      rdata;
    logic            busy;
    int n_cmp = 0;
    int n_bad = 0;
    texture_rom_arbiter #(.NUM_REQ(N), .TEX_ID_W(TW), .ROM_LAT(LAT)) dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .req        (req),
        .tex_id     (tex_id),
        .tex_u      (tex_u),
        .tex_v      (tex_v),
        .gnt        (gnt),
        .rom_address(rom_address),
        .rom_q      (rom_q),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .busy       (busy)
    );
    always #5 vga_clk = ~vga_clk;
    // ROM model: 0x235 -> 0xA7, 0x01A -> 0x08, 0x12B -> 0x79, 0x23C -> 0xAE, 0x34D -> 0x9F
    always @(negedge vga_clk) rom_q <= rom_address[7:0] ^ {rom_address[9:8], 6'h12};
    task automatic tick;
        @(posedge vga_clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        tex_id = {2'd3, 2'd2, 2'd1, 2'd0};
        tex_u  = {4'hD, 4'hC, 4'hB, 4'hA};
        tex_v  = {4'h4, 4'h3, 4'h2, 4'h1};
        req    = 4'b1111;
        #2 reset_n = 1'b0;
        tick;
        tick;
        chk("rst_gnt", 16'(gnt), 16'h0);
        chk("rst_rvalid", 16'(rvalid), 16'h0);
        chk("rst_rdata", 16'(rdata), 16'h0);
        chk("rst_addr", 16'(rom_address), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        reset_n = 1'b1;
        tick;
        chk("rr0_gnt", 16'(gnt), 16'h1);
        chk("rr0_addr", 16'(rom_address), 16'h01A);
        chk("rr0_rvalid", 16'(rvalid), 16'h0);
        chk("rr0_busy", 16'(busy), 16'h1);
        tick;
        chk("rr1_gnt", 16'(gnt), 16'h2);
        chk("rr1_addr", 16'(rom_address), 16'h12B);
        chk("rr1_rvalid", 16'(rvalid), 16'h1);
        chk("rr1_rdata", 16'(rdata), 16'h08);
        tick;
        chk("rr2_gnt", 16'(gnt), 16'h4);
        chk("rr2_rvalid", 16'(rvalid), 16'h2);
        chk("rr2_rdata", 16'(rdata), 16'h79);
        tick;
        chk("rr3_gnt", 16'(gnt), 16'h8);
        chk("rr3_rvalid", 16'(rvalid), 16'h4);
        chk("rr3_rdata", 16'(rdata), 16'hAE);
        tick;
        chk("rr4_gnt", 16'(gnt), 16'h1);
        chk("rr4_rvalid", 16'(rvalid), 16'h8);
        chk("rr4_rdata", 16'(rdata), 16'h9F);
        req = 4'b0000;
        tick;
        chk("rr5_gnt", 16'(gnt), 16'h0);
        chk("rr5_rvalid", 16'(rvalid), 16'h1);
        chk("rr5_rdata", 16'(rdata), 16'h08);
        tick;
        chk("rr6_rvalid", 16'(rvalid), 16'h0);
        chk("rr6_busy", 16'(busy), 16'h0);
        tex_id[1:0] = 2'd2;
        tex_u[3:0]  = 4'h5;
        tex_v[3:0]  = 4'h3;
        req = 4'b0001;
        tick;
        chk("one_gnt", 16'(gnt), 16'h1);
        chk("one_addr", 16'(rom_address), 16'h235);
        req = 4'b0000;
        tick;
        chk("one_gnt_off", 16'(gnt), 16'h0);
        chk("one_rvalid", 16'(rvalid), 16'h1);
        chk("one_rdata", 16'(rdata), 16'hA7);
        tick;
        chk("one_rvalid_off", 16'(rvalid), 16'h0);
        chk("one_rdata_hold", 16'(rdata), 16'hA7);
        chk("one_busy_off", 16'(busy), 16'h0);
        req = 4'b0100;
        tick;
        chk("c2_gnt_a", 16'(gnt), 16'h4);
        chk("c2_busy_a", 16'(busy), 16'h1);
        tick;
        chk("c2_gnt_b", 16'(gnt), 16'h0);
        chk("c2_rvalid_b", 16'(rvalid), 16'h4);
        chk("c2_busy_b", 16'(busy), 16'h1);
        tick;
        chk("c2_gnt_c", 16'(gnt), 16'h4);
        chk("c2_busy_c", 16'(busy), 16'h1);
        tick;
        chk("c2_gnt_d", 16'(gnt), 16'h0);
        chk("c2_busy_d", 16'(busy), 16'h1);
        req = 4'b1010;
        tick;
        chk("wrap_gnt3", 16'(gnt), 16'h8);
        chk("wrap_addr3", 16'(rom_address), 16'h34D);
        req = 4'b0010;
        tick;
        chk("wrap_gnt1", 16'(gnt), 16'h2);
        chk("wrap_addr1", 16'(rom_address), 16'h12B);
        chk("wrap_rvalid3", 16'(rvalid), 16'h8);
        chk("wrap_rdata3", 16'(rdata), 16'h9F);
        req = 4'b0000;
        tick;
        chk("wrap_rvalid1", 16'(rvalid), 16'h2);
        chk("wrap_rdata1", 16'(rdata), 16'h79);
        req = 4'b0011;
        tick;
        chk("mid_gnt0", 16'(gnt), 16'h1);
        req = 4'b0010;
        tick;
        chk("mid_gnt1", 16'(gnt), 16'h2);
        chk("mid_rvalid0", 16'(rvalid), 16'h1);
        reset_n = 1'b0;
        req = 4'b0000;
        #1;
        chk("mid_rst_gnt", 16'(gnt), 16'h0);
        chk("mid_rst_rvalid", 16'(rvalid), 16'h0);
        chk("mid_rst_rdata", 16'(rdata), 16'h0);
        chk("mid_rst_addr", 16'(rom_address), 16'h0);
        chk("mid_rst_busy", 16'(busy), 16'h0);
        tick;
        chk("mid_rst_hold_rvalid", 16'(rvalid), 16'h0);
        reset_n = 1'b1;
        tick;
        chk("post_rst_rvalid", 16'(rvalid), 16'h0);
        chk("post_rst_gnt", 16'(gnt), 16'h0);
        req = 4'b0111;
        tick;
        chk("ptr_restart_gnt", 16'(gnt), 16'h1);
        req = 4'b0100;
        tick;
        chk("drop_gnt", 16'(gnt), 16'h4);
        chk("drop_rvalid0", 16'(rvalid), 16'h1);
        req = 4'b0000;
        tick;
        chk("drop_gnt_off", 16'(gnt), 16'h0);
        chk("drop_rvalid2", 16'(rvalid), 16'h4);
        tick;
        chk("drop_rvalid_off", 16'(rvalid), 16'h0);
        chk("drop_busy_off", 16'(busy), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
